// File: rtl/alu_multicycle.sv
// Registered E-stage ALU with a start/ready/done handshake. Single-cycle ops finish
// on the accept edge. MULTU (shift-add) and DIVU (restoring) iterate one bit per clock.
module alu_multicycle #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startALU,
  input  logic [WIDTH-1:0]   operandOneALU,
  input  logic [WIDTH-1:0]   operandTwoALU,
  input  logic [3:0]         ControlValueALU,
  output logic               readyALU,
  output logic               doneALU,
  output logic [WIDTH-1:0]   resultALU,
  output logic [WIDTH-1:0]   resultHiALU,
  output logic               zeroALU,
  output logic               divByZeroALU
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_MULTU = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_SRL   = 4'd5;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_SLT   = 4'd7;
  localparam logic [3:0] OP_LUI   = 4'd8;
  localparam logic [3:0] OP_SLL   = 4'd9;
  localparam logic [3:0] OP_NOR   = 4'd10;
  localparam logic [3:0] OP_XOR   = 4'd11;

  localparam logic [SHAMT_W-1:0] CNT_INIT = SHAMT_W'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               mul_q, mul_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic               zero_q, zero_d;
  logic               div_by_zero_q, div_by_zero_d;

  logic [WIDTH-1:0]   alu_res;
  logic [SHAMT_W-1:0] shamt;
  logic               accept;
  logic               long_op;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   acc_nx;
  logic [WIDTH-1:0]   lo_nx;

  assign shamt   = operandTwoALU[SHAMT_W-1:0];
  assign accept  = startALU && (state_q != S_RUN);
  assign long_op = (ControlValueALU == OP_MULTU) || (ControlValueALU == OP_DIVU);

  // NOTE: every always_comb output gets a default before the case, so no latch is inferred.
  always_comb begin
    alu_res = '0;
    case (ControlValueALU)
      OP_AND:  alu_res = operandOneALU & operandTwoALU;
      OP_OR:   alu_res = operandOneALU | operandTwoALU;
      OP_ADD:  alu_res = operandOneALU + operandTwoALU;
      OP_SRL:  alu_res = operandOneALU >> shamt;
      OP_SUB:  alu_res = operandOneALU - operandTwoALU;
      OP_SLT:  alu_res = ($signed(operandOneALU) < $signed(operandTwoALU)) ? WIDTH'(1) : '0;
      OP_LUI:  alu_res = {operandTwoALU[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SLL:  alu_res = operandOneALU << shamt;
      OP_NOR:  alu_res = ~(operandOneALU | operandTwoALU);
      OP_XOR:  alu_res = operandOneALU ^ operandTwoALU;
      default: alu_res = '0;
    endcase
  end

  // Multiply: {acc, lo} shifts right, adding B into acc when the multiplier LSB is set.
  // Divide: {acc, lo} shifts left, acc is the partial remainder, lo collects quotient bits.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {acc_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_ge    = !div_diff[WIDTH];
    if (mul_q) begin
      acc_nx = mul_sum[WIDTH:1];
      lo_nx  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      acc_nx = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      lo_nx  = {lo_q[WIDTH-2:0], div_ge};
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mul_d         = mul_q;
    b_d           = b_q;
    acc_d         = acc_q;
    lo_d          = lo_q;
    result_d      = result_q;
    result_hi_d   = result_hi_q;
    zero_d        = zero_q;
    div_by_zero_d = div_by_zero_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          if (long_op) begin
            state_d = S_RUN;
            cnt_d   = CNT_INIT;
            mul_d   = (ControlValueALU == OP_MULTU);
            b_d     = operandTwoALU;
            lo_d    = operandOneALU;
            acc_d   = '0;
          end else begin
            state_d       = S_DONE;
            result_d      = alu_res;
            result_hi_d   = '0;
            zero_d        = (alu_res == '0);
            div_by_zero_d = 1'b0;
          end
        end
      end
      S_RUN: begin
        acc_d = acc_nx;
        lo_d  = lo_nx;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d       = S_DONE;
          result_d      = lo_nx;
          result_hi_d   = acc_nx;
          zero_d        = (lo_nx == '0);
          div_by_zero_d = !mul_q && (b_q == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      mul_q         <= 1'b0;
      b_q           <= '0;
      acc_q         <= '0;
      lo_q          <= '0;
      result_q      <= '0;
      result_hi_q   <= '0;
      zero_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mul_q         <= mul_d;
      b_q           <= b_d;
      acc_q         <= acc_d;
      lo_q          <= lo_d;
      result_q      <= result_d;
      result_hi_q   <= result_hi_d;
      zero_q        <= zero_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign readyALU     = (state_q != S_RUN);
  assign doneALU      = (state_q == S_DONE);
  assign resultALU    = result_q;
  assign resultHiALU  = result_hi_q;
  assign zeroALU      = zero_q;
  assign divByZeroALU = div_by_zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: a driver queues reference results, a monitor
// pops and compares them on every doneALU. A second 8-bit instance gets directed checks.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        startALU = 1'b0;
  logic [31:0] a_in = '0, b_in = '0;
  logic [3:0]  op_in = '0;
  logic        readyALU, doneALU, zeroALU, divByZeroALU;
  logic [31:0] resultALU, resultHiALU;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [3:0]  op8 = '0;
  logic        ready8, done8, zero8, dbz8;
  logic [7:0]  res8, hi8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        zero;
    logic        dbz;
    int          lat;
    int          due;
    logic [3:0]  op;
  } exp_t;

  exp_t scb[$];

  alu_multicycle #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset), .startALU(startALU),
    .operandOneALU(a_in), .operandTwoALU(b_in), .ControlValueALU(op_in),
    .readyALU(readyALU), .doneALU(doneALU), .resultALU(resultALU),
    .resultHiALU(resultHiALU), .zeroALU(zeroALU), .divByZeroALU(divByZeroALU)
  );

  alu_multicycle #(.WIDTH(8), .SHAMT_W(3)) dut8 (
    .clk(clk), .reset(reset), .startALU(start8),
    .operandOneALU(a8), .operandTwoALU(b8), .ControlValueALU(op8),
    .readyALU(ready8), .doneALU(done8), .resultALU(res8),
    .resultHiALU(hi8), .zeroALU(zero8), .divByZeroALU(dbz8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", scb.size());
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: plain arithmetic on the operation's definition.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] p;
    e.hi = '0; e.dbz = 1'b0; e.lat = 1; e.op = op; e.due = 0;
    case (op)
      4'd0:  e.lo = a & b;
      4'd1:  e.lo = a | b;
      4'd2:  e.lo = a + b;
      4'd3: begin
        p = {32'b0, a} * {32'b0, b};
        e.lo = p[31:0]; e.hi = p[63:32]; e.lat = 33;
      end
      4'd4: begin
        e.lat = 33;
        if (b == 0) begin e.lo = '1; e.hi = a; e.dbz = 1'b1; end
        else begin e.lo = a / b; e.hi = a % b; end
      end
      4'd5:  e.lo = a >> b[4:0];
      4'd6:  e.lo = a - b;
      4'd7:  e.lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:  e.lo = {b[15:0], 16'h0000};
      4'd9:  e.lo = a << b[4:0];
      4'd10: e.lo = ~(a | b);
      4'd11: e.lo = a ^ b;
      default: e.lo = '0;
    endcase
    e.zero = (e.lo == 0);
    return e;
  endfunction

  // Monitor: every doneALU pulse must match the oldest outstanding request.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (doneALU) begin
        if (scb.size() == 0) begin
          check("done_unexpected", doneALU, 1'b0);
        end else begin
          e = scb.pop_front();
          check($sformatf("lo op%0d", e.op), resultALU, e.lo);
          check($sformatf("hi op%0d", e.op), resultHiALU, e.hi);
          check($sformatf("zero op%0d", e.op), zeroALU, e.zero);
          check($sformatf("dbz op%0d", e.op), divByZeroALU, e.dbz);
          check($sformatf("latency op%0d", e.op), cyc, e.due);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int n = 0;
    while (!readyALU && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", readyALU, 1'b1);
    op_in = op; a_in = a; b_in = b; startALU = 1'b1;
    e = model(op, a, b);
    e.due = cyc + e.lat;
    scb.push_back(e);
    @(negedge clk);
    startALU = 1'b0;
    a_in = $urandom; b_in = $urandom; op_in = 4'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (scb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", scb.size(), 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 40));
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp_lo, input logic [7:0] exp_hi, input int lat);
    int n;
    check("w8 ready", ready8, 1'b1);
    op8 = op; a8 = a; b8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 1;
    while (!done8 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("w8 done op%0d", op), done8, 1'b1);
    check($sformatf("w8 latency op%0d", op), n, lat);
    check($sformatf("w8 lo op%0d", op), res8, exp_lo);
    check($sformatf("w8 hi op%0d", op), hi8, exp_hi);
    @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst ready", readyALU, 1'b1);
    check("rst done", doneALU, 1'b0);
    check("rst lo", resultALU, 0);
    check("rst zero", zeroALU, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Reset in the middle of a MULTU aborts it with no done pulse.
    issue(4'd3, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort ready", readyALU, 1'b1);
    check("abort done", doneALU, 1'b0);
    check("abort lo", resultALU, 0);
    check("abort hi", resultHiALU, 0);
    check("abort zero", zeroALU, 1'b0);
    check("abort dbz", divByZeroALU, 1'b0);
    scb.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(4'd2, 32'd2, 32'd3);
    drain();

    issue(4'd6, 32'd7, 32'd7);
    issue(4'd7, 32'hFFFF_FFFF, 32'd1);
    issue(4'd5, 32'h8000_0000, 32'd31);
    issue(4'd8, 32'd0, 32'h0000_1234);
    issue(4'd13, 32'd5, 32'd9);
    drain();

    // MULTU worst case; a start pulse during RUN must be ignored.
    issue(4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n = 0;
    while (!readyALU && n < 100) begin
      n++;
      if (n == 5) begin
        startALU = 1'b1; op_in = 4'd2; a_in = 32'd1; b_in = 32'd1;
      end else begin
        startALU = 1'b0;
      end
      @(negedge clk);
    end
    startALU = 1'b0;
    check("ready_low_cycles", n, 32);
    drain();

    issue(4'd4, 32'd100, 32'd7);
    issue(4'd4, 32'd100, 32'd0);
    drain();

    // Back-to-back: DIVU accepted in ADD's DONE, AND accepted in DIVU's DONE.
    issue(4'd2, 32'd40, 32'd2);
    issue(4'd4, 32'd1000, 32'd33);
    issue(4'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    drain();

    for (int i = 0; i < 60; i++) begin
      issue(4'($urandom_range(0, 15)), pick(), pick());
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    run8(4'd3, 8'hFF, 8'hFF, 8'h01, 8'hFE, 9);
    run8(4'd9, 8'h01, 8'h07, 8'h80, 8'h00, 1);
    run8(4'd4, 8'd200, 8'd7, 8'd28, 8'd4, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised, registered successor to the Execute-stage ALU.
- Adds a start/ready/done handshake, signed SLT, XOR, a correct SRL/SLL pair, and iterative unsigned MULTU/DIVU with a HI/LO result pair.
- Single-cycle ops complete in 1 clock; MULTU/DIVU complete in WIDTH+1 clocks.
- Sits in the E stage; the pipeline controller stalls on readyALU low.

Parameters:
- WIDTH, 32, operand/result width; must be even and >= 4.
- SHAMT_W, 5, shift-amount bits taken from operandTwoALU; must equal log2(WIDTH).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- startALU  in  1  request; accepted on a rising edge when startALU && readyALU.
- operandOneALU  in  WIDTH  operand A, sampled on the accept edge.
- operandTwoALU  in  WIDTH  operand B, sampled on the accept edge.
- ControlValueALU  in  4  operation select, sampled on the accept edge.
- readyALU  out  1  high when a new request can be accepted.
- doneALU  out  1  one-cycle pulse: result outputs updated this cycle.
- resultALU  out  WIDTH  result (LO for MULTU/DIVU).
- resultHiALU  out  WIDTH  HI word for MULTU/DIVU; 0 for other ops.
- zeroALU  out  1  resultALU == 0, registered with the result.
- divByZeroALU  out  1  DIVU with operandTwoALU == 0; registered with the result.

Behaviour:
- Reset (async): state IDLE; all outputs 0 except readyALU = 1; counter, accumulators and latched operands cleared.
- Reset mid-RUN aborts the operation: no doneALU pulse, outputs go to their reset values.
- States:
  - IDLE: on accept, single-cycle op -> DONE; MULTU/DIVU -> RUN with counter = WIDTH-1.
  - RUN: one iteration per clock. When counter == 0, take that iteration's result and go to DONE; otherwise decrement.
  - DONE: doneALU = 1 for exactly this cycle. On accept go to DONE (single-cycle op) or RUN; otherwise go to IDLE.
- readyALU = (state != RUN). Back-to-back accepts in DONE give consecutive doneALU pulses.
- Latency, counted from the accept edge to the cycle where doneALU = 1:
  - Single-cycle ops: 1 edge.
  - MULTU/DIVU: WIDTH+1 edges (WIDTH iteration edges in RUN, then DONE).
- startALU while in RUN is ignored; no queuing.
- Operands are latched on accept; input changes afterwards have no effect.
- Result, HI, zero and divByZero update only on the edge entering DONE, and hold until the next completion.
- Op encodings (resultHiALU = 0 for all except MULTU/DIVU):
  - 0 AND
  - 1 OR
  - 2 ADD, mod 2^WIDTH, no overflow flag
  - 3 MULTU: {resultHiALU, resultALU} = A*B unsigned, 2*WIDTH bits; shift-add, one partial product per cycle
  - 4 DIVU: resultALU = A/B, resultHiALU = A%B; restoring division, one quotient bit per cycle
  - 5 SRL: A >> B[SHAMT_W-1:0], logical
  - 6 SUB: A - B, mod 2^WIDTH
  - 7 SLT: signed compare; 1 if A < B, else 0
  - 8 LUI: {B[WIDTH/2-1:0], WIDTH/2 zeros}
  - 9 SLL: A << B[SHAMT_W-1:0]
  - 10 NOR: ~(A | B)
  - 11 XOR
  - 12-15: result 0, zeroALU = 1, latency 1
- DIVU with B == 0:
  - Still takes WIDTH+1 edges.
  - resultALU = all ones; resultHiALU = A; divByZeroALU = 1.
- divByZeroALU = 0 for every other completion.
- zeroALU reflects resultALU only, never resultHiALU.

Test Plan:
- Reset asserted mid-RUN of MULTU -> outputs 0 and readyALU = 1 immediately, no doneALU pulse; a new ADD 2+3 afterwards -> doneALU 1 edge later, resultALU = 5, zeroALU = 0.
- SUB 7-7 -> resultALU = 0, zeroALU = 1. SLT 0xFFFFFFFF vs 1 -> 1 (signed). SRL 0x80000000 by 31 -> 1. LUI B = 0x1234 -> 0x12340000.
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> doneALU exactly 33 edges after accept, resultHiALU = 0xFFFFFFFE, resultALU = 0x00000001; readyALU low for 32 cycles; a startALU pulse during RUN is ignored.
- DIVU 100/7 -> resultALU = 14, resultHiALU = 2, divByZeroALU = 0. DIVU 100/0 -> resultALU = 0xFFFFFFFF, resultHiALU = 100, divByZeroALU = 1, latency 33.
- Back-to-back: ADD accepted, then DIVU accepted in the DONE cycle, then AND accepted in the DIVU DONE cycle -> three doneALU pulses with correct results and no lost request.
- WIDTH=8, SHAMT_W=3: MULTU 0xFF*0xFF -> HI 0xFE, LO 0x01 after 9 edges; SLL 0x01 by 7 -> 0x80.
